// File: rtl/bisr_output_merge_os_pkg.sv
// Shared types for the BISR output merge: FSM state encoding, error flag
// bit positions and an index-width helper.
package bisr_output_merge_os_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_WAIT_RU = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    localparam int ERR_OVERRUN   = 0;
    localparam int ERR_COLLISION = 1;
    localparam int ERR_TIMEOUT   = 2;

    // Index width that never collapses to zero for single-entry dimensions.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bisr_output_merge_os_if.sv
// Systolic drain, RU repair and downstream row stream of the output merge.
interface bisr_output_merge_os_if
    import bisr_output_merge_os_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int WORD_SIZE = 16,
    parameter int NUM_RU    = 4
) ();
    localparam int CW = idx_w(COLS);
    localparam int RW = idx_w(ROWS);

    logic                          sys_valid;
    logic [COLS*WORD_SIZE-1:0]     systolic_bottom_out;
    logic [NUM_RU-1:0]             ru_expect;
    logic [NUM_RU-1:0]             ru_output_valid;
    logic [NUM_RU*WORD_SIZE-1:0]   rcm_bottom_out;
    logic [CW*NUM_RU-1:0]          ru_col_mapping;
    logic [CW*NUM_RU-1:0]          ru_row_mapping;
    logic                          out_valid;
    logic                          out_ready;
    logic [COLS*WORD_SIZE-1:0]     out_data;
    logic [RW-1:0]                 out_row;
    logic                          out_last;

    modport slave (
        input  sys_valid, systolic_bottom_out, ru_expect, ru_output_valid,
               rcm_bottom_out, ru_col_mapping, ru_row_mapping, out_ready,
        output out_valid, out_data, out_row, out_last
    );

    modport master (
        output sys_valid, systolic_bottom_out, ru_expect, ru_output_valid,
               rcm_bottom_out, ru_col_mapping, ru_row_mapping, out_ready,
        input  out_valid, out_data, out_row, out_last
    );
endinterface

// File: rtl/bisr_output_merge_os_patch_buffer.sv
// ROWSxCOLS result storage with a per-element patch mask; RU writes override
// systolic row writes and protect the element from later row writes.
module bisr_patch_buffer #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int W      = 16,
    parameter int NUM_RU = 4,
    parameter int RW     = 2,
    parameter int CW     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_mask_i,
    input  logic                         row_we_i,
    input  logic [RW-1:0]                row_wa_i,
    input  logic [COLS-1:0][W-1:0]       row_wd_i,
    input  logic [NUM_RU-1:0]            ru_we_i,
    input  logic [NUM_RU-1:0][CW-1:0]    ru_row_i,
    input  logic [NUM_RU-1:0][CW-1:0]    ru_col_i,
    input  logic [NUM_RU-1:0][W-1:0]     ru_wd_i,
    input  logic [RW-1:0]                rd_row_i,
    output logic [COLS-1:0][W-1:0]       rd_data_o,
    output logic                         collide_o
);
    logic [ROWS-1:0][COLS-1:0][W-1:0] mem_q;
    logic [ROWS-1:0][COLS-1:0]        mask_q;
    logic [ROWS-1:0][COLS-1:0]        hit;
    logic [ROWS-1:0][COLS-1:0][W-1:0] hval;
    logic                             coll;

    // Ascending scan: a later (higher-index) RU overrides an earlier hit.
    always_comb begin
        hit  = '0;
        hval = '0;
        coll = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                for (int i = 0; i < NUM_RU; i++) begin
                    if (ru_we_i[i] && ru_row_i[i] == CW'(r) && ru_col_i[i] == CW'(c)) begin
                        coll       = coll | hit[r][c];
                        hit[r][c]  = 1'b1;
                        hval[r][c] = ru_wd_i[i];
                    end
                end
            end
        end
    end

    assign collide_o = coll;

    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (hit[r][c])
                    mem_q[r][c] <= hval[r][c];
                else if (row_we_i && row_wa_i == RW'(r) && !mask_q[r][c])
                    mem_q[r][c] <= row_wd_i[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mask_q <= '0;
        else if (clr_mask_i)
            mask_q <= '0;
        else
            mask_q <= mask_q | hit;
    end

    assign rd_data_o = mem_q[rd_row_i];

endmodule

// File: rtl/bisr_output_merge_os.sv
// BISR output merge: captures drained systolic rows, patches faulty elements
// with RU results and streams the corrected matrix over valid/ready.
module bisr_output_merge_os
    import bisr_output_merge_os_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int WORD_SIZE  = 16,
    parameter int NUM_RU     = 4,
    parameter int RU_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bisr_output_merge_os_if.slave   bus,
    input  logic                    err_clr_i,
    output logic                    busy_o,
    output logic [2:0]              err_flags_o
);
    localparam int CW = idx_w(COLS);
    localparam int RW = idx_w(ROWS);
    localparam int TW = $clog2(RU_TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [RW-1:0]        wr_row_q, wr_row_d, rd_row_q, rd_row_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [NUM_RU-1:0]    exp_q, exp_d;
    logic [2:0]           err_q, err_d;

    logic [NUM_RU-1:0][CW-1:0]        ru_row, ru_col;
    logic [NUM_RU-1:0][WORD_SIZE-1:0] ru_wd;
    logic [NUM_RU-1:0]                ru_take, ru_oob, ru_we;
    logic [NUM_RU-1:0]                exp_after;
    logic [COLS-1:0][WORD_SIZE-1:0]   rd_data;
    logic patch_en, row_we, last_wr, last_rd, out_valid, handshake, clr_mask, collide;

    assign patch_en = (state_q == ST_CAPTURE) || (state_q == ST_WAIT_RU);

    for (genvar i = 0; i < NUM_RU; i++) begin : g_ru
        assign ru_row[i]  = bus.ru_row_mapping[i*CW +: CW];
        assign ru_col[i]  = bus.ru_col_mapping[i*CW +: CW];
        assign ru_wd[i]   = bus.rcm_bottom_out[i*WORD_SIZE +: WORD_SIZE];
        assign ru_take[i] = patch_en && bus.ru_output_valid[i] && exp_q[i];
        assign ru_oob[i]  = {1'b0, ru_row[i]} >= (CW+1)'(ROWS);
        assign ru_we[i]   = ru_take[i] && !ru_oob[i];
    end

    assign exp_after = exp_q & ~ru_take;
    assign row_we    = bus.sys_valid && ((state_q == ST_IDLE) || (state_q == ST_CAPTURE));
    assign last_wr   = (wr_row_q == RW'(ROWS - 1));
    assign last_rd   = (rd_row_q == RW'(ROWS - 1));
    assign out_valid = (state_q == ST_DRAIN);
    assign handshake = out_valid && bus.out_ready;

    bisr_patch_buffer #(
        .ROWS(ROWS), .COLS(COLS), .W(WORD_SIZE), .NUM_RU(NUM_RU), .RW(RW), .CW(CW)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_mask_i (clr_mask),
        .row_we_i   (row_we),
        .row_wa_i   (wr_row_q),
        .row_wd_i   (bus.systolic_bottom_out),
        .ru_we_i    (ru_we),
        .ru_row_i   (ru_row),
        .ru_col_i   (ru_col),
        .ru_wd_i    (ru_wd),
        .rd_row_i   (rd_row_q),
        .rd_data_o  (rd_data),
        .collide_o  (collide)
    );

    always_comb begin
        state_d  = state_q;
        wr_row_d = wr_row_q;
        rd_row_d = rd_row_q;
        timer_d  = timer_q;
        exp_d    = exp_q;
        clr_mask = 1'b0;
        err_d    = err_clr_i ? 3'b000 : err_q;
        unique case (state_q)
            ST_IDLE: if (bus.sys_valid) begin
                exp_d = bus.ru_expect;
                if (ROWS == 1) begin
                    state_d = (bus.ru_expect == '0) ? ST_DRAIN : ST_WAIT_RU;
                end else begin
                    state_d  = ST_CAPTURE;
                    wr_row_d = RW'(1);
                end
            end
            ST_CAPTURE: begin
                exp_d = exp_after;
                if (bus.sys_valid) begin
                    if (last_wr)
                        state_d = (exp_after == '0) ? ST_DRAIN : ST_WAIT_RU;
                    else
                        wr_row_d = wr_row_q + RW'(1);
                end
            end
            ST_WAIT_RU: begin
                exp_d = exp_after;
                if (bus.sys_valid) err_d[ERR_OVERRUN] = 1'b1;
                if (exp_after == '0) begin
                    state_d = ST_DRAIN;
                end else if (timer_q == TW'(RU_TIMEOUT - 1)) begin
                    state_d            = ST_DRAIN;
                    exp_d              = '0;
                    err_d[ERR_TIMEOUT] = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_DRAIN: begin
                if (bus.sys_valid) err_d[ERR_OVERRUN] = 1'b1;
                if (handshake) begin
                    if (last_rd) begin
                        state_d  = ST_IDLE;
                        rd_row_d = '0;
                        wr_row_d = '0;
                        timer_d  = '0;
                        clr_mask = 1'b1;
                    end else begin
                        rd_row_d = rd_row_q + RW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Out-of-range targets and same-element RU conflicts both count as collisions.
        if (|(ru_take & ru_oob) || collide) err_d[ERR_COLLISION] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_row_q <= '0;
            rd_row_q <= '0;
            timer_q  <= '0;
            exp_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_row_q <= wr_row_d;
            rd_row_q <= rd_row_d;
            timer_q  <= timer_d;
            exp_q    <= exp_d;
            err_q    <= err_d;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? rd_data : '0;
    assign bus.out_row   = rd_row_q;
    assign bus.out_last  = out_valid && last_rd;
    assign busy_o        = (state_q != ST_IDLE);
    assign err_flags_o   = err_q;

endmodule

// File: tb/tb_bisr_output_merge_os.sv
// Directed scoreboard bench for bisr_output_merge_os (4x4, 16-bit, 4 RUs).
module tb_bisr_output_merge_os;
    localparam int ROWS = 4, COLS = 4, WS = 16, NRU = 4, TMO = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       err_clr = 1'b0;
    logic       busy;
    logic [2:0] err_flags;

    bisr_output_merge_os_if #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WS), .NUM_RU(NRU)) bus ();

    bisr_output_merge_os #(
        .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WS), .NUM_RU(NRU), .RU_TIMEOUT(TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .err_clr_i   (err_clr),
        .busy_o      (busy),
        .err_flags_o (err_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        int          row;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m [ROWS][COLS];
    int          vec_cnt = 0;
    int          err_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vec_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] pack(input int r);
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++) v[c*WS +: WS] = m[r][c];
        return v;
    endfunction

    task automatic fill(input logic [15:0] base);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m[r][c] = base + 16'(16*r + c);
    endtask

    task automatic push_exp();
        exp_t e;
        for (int r = 0; r < ROWS; r++) begin
            e.data = pack(r);
            e.row  = r;
            e.last = (r == ROWS - 1);
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Systolic row carries the unpatched pattern: base + 16*r + c.
    task automatic send_row(input logic [15:0] base, input int r);
        logic [63:0] v;
        for (int c = 0; c < COLS; c++) v[c*WS +: WS] = base + 16'(16*r + c);
        bus.sys_valid           = 1'b1;
        bus.systolic_bottom_out = v;
        tick();
        bus.sys_valid = 1'b0;
    endtask

    task automatic ru_map(input int i, input int row, input int col, input logic [15:0] val);
        logic [1:0] rr, cc;
        rr = 2'(row);
        cc = 2'(col);
        bus.ru_row_mapping[i*2 +: 2] = rr;
        bus.ru_col_mapping[i*2 +: 2] = cc;
        bus.rcm_bottom_out[i*WS +: WS] = val;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check(name, busy, 1'b0);
    endtask

    // Monitor: every accepted output row is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL unexpected row: got row %0d data %h expected none", bus.out_row, bus.out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", bus.out_data, e.data);
                check("out_row", 64'(bus.out_row), 64'(e.row));
                check("out_last", 64'(bus.out_last), 64'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        bus.sys_valid = 0; bus.systolic_bottom_out = '0; bus.ru_expect = '0;
        bus.ru_output_valid = '0; bus.rcm_bottom_out = '0; bus.ru_col_mapping = '0;
        bus.ru_row_mapping = '0; bus.out_ready = 1'b1;
        tick(); tick();
        check("rst out_valid", bus.out_valid, 1'b0);
        check("rst out_data", bus.out_data, 64'h0);
        check("rst out_last", bus.out_last, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst err", err_flags, 3'b000);
        rst_n = 1'b1;
        tick();

        // No faults: drain starts the cycle after row 3.
        fill(16'h0000); push_exp();
        for (int r = 0; r < ROWS; r++) send_row(16'h0000, r);
        check("t1 drain start", bus.out_valid, 1'b1);
        wait_idle("t1 idle");
        check("t1 err", err_flags, 3'b000);

        // Late repair: RU0 -> (2,1) strobes well after the last row.
        fill(16'h0100); m[2][1] = 16'hBEEF; push_exp();
        bus.ru_expect = 4'b0001; ru_map(0, 2, 1, 16'hBEEF);
        for (int r = 0; r < ROWS; r++) send_row(16'h0100, r);
        bus.ru_expect = 4'b0000;
        repeat (4) tick();
        check("t2 waiting no valid", bus.out_valid, 1'b0);
        check("t2 waiting busy", busy, 1'b1);
        bus.ru_output_valid = 4'b0001; tick(); bus.ru_output_valid = 4'b0000;
        check("t2 drain after strobe", bus.out_valid, 1'b1);
        wait_idle("t2 idle");
        check("t2 err", err_flags, 3'b000);

        // Early repair: RU1 -> (3,0) arrives before row 3 and must survive it.
        fill(16'h0200); m[3][0] = 16'h1234; push_exp();
        bus.ru_expect = 4'b0010; ru_map(1, 3, 0, 16'h1234);
        send_row(16'h0200, 0);
        bus.ru_expect = 4'b0000;
        bus.ru_output_valid = 4'b0010; tick(); bus.ru_output_valid = 4'b0000;
        for (int r = 1; r < ROWS; r++) send_row(16'h0200, r);
        check("t3 drain start", bus.out_valid, 1'b1);
        wait_idle("t3 idle");
        check("t3 err", err_flags, 3'b000);

        // Collision: RU0 and RU2 hit (1,1) together, same edge as systolic row 1.
        fill(16'h0300); m[1][1] = 16'h2222; push_exp();
        bus.ru_expect = 4'b0101; ru_map(0, 1, 1, 16'h1111); ru_map(2, 1, 1, 16'h2222);
        send_row(16'h0300, 0);
        bus.ru_expect = 4'b0000;
        bus.ru_output_valid = 4'b0101;
        send_row(16'h0300, 1);
        bus.ru_output_valid = 4'b0000;
        for (int r = 2; r < ROWS; r++) send_row(16'h0300, r);
        check("t4 drain start", bus.out_valid, 1'b1);
        wait_idle("t4 idle");
        check("t4 err collision", err_flags, 3'b010);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("t4 err cleared", err_flags, 3'b000);

        // Timeout with backpressure, then reset mid-drain.
        fill(16'h0400); push_exp();
        bus.out_ready = 1'b0;
        bus.ru_expect = 4'b0001; ru_map(0, 0, 0, 16'hDEAD);
        for (int r = 0; r < ROWS; r++) send_row(16'h0400, r);
        bus.ru_expect = 4'b0000;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        check("t5 timeout cycles", 64'(n), 64'(TMO));
        check("t5 err timeout", err_flags, 3'b100);
        for (int k = 0; k < 3; k++) begin
            check("t5 stall data", bus.out_data, pack(0));
            check("t5 stall row", 64'(bus.out_row), 64'h0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick(); tick();
        check("t5 mid-drain row", 64'(bus.out_row), 64'h2);
        rst_n = 1'b0;
        #1;
        check("t5 reset out_valid", bus.out_valid, 1'b0);
        check("t5 reset busy", busy, 1'b0);
        check("t5 reset out_data", bus.out_data, 64'h0);
        check("t5 reset err", err_flags, 3'b000);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();

        // Overrun: a systolic row during drain is dropped and flagged.
        fill(16'h0500); push_exp();
        for (int r = 0; r < ROWS; r++) send_row(16'h0500, r);
        check("t6 drain start", bus.out_valid, 1'b1);
        send_row(16'h0F00, 0);
        wait_idle("t6 idle");
        check("t6 err overrun", err_flags, 3'b001);

        check("scoreboard empty", 64'(sb.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
